esm_config_decoder: RTL and testbench
=====================================

# esm_config_decoder

Single-clock AXI-stream configuration decoder for the ESM receiver. It accepts 32-bit control messages from the host DMA and validates the 4-word header. Common "enables" messages are applied to local control registers. All other messages have their payload forwarded, one word per cycle, to downstream modules (dwell controller, etc.) over the `Module_config` bus.

## Interface
Parameters:
- `AXI_DATA_WIDTH`, 32: stream word width; only 32 is supported.
- `CONTROL_MAGIC_NUM`, 32'h45534D43: required value of header word 0.
- `MODULE_ID_COMMON`, 8'h00: module ID whose messages are decoded locally.
- `MSG_TYPE_ENABLES`, 8'h00: message type of the common enables message.

Ports (all synchronous to `S_axis_clk`; reset is synchronous and active-low):
- `S_axis_clk`  in  1  the single clock.
- `S_axis_resetn`  in  1  synchronous active-low reset.
- `S_axis_ready`  out  1  stream ready.
- `S_axis_valid`  in  1  stream valid.
- `S_axis_data`  in  32  stream word.
- `S_axis_last`  in  1  last word of message.
- `Rst_out`  out  1  downstream soft reset, level.
- `Enable_status`  out  1  status reporter enable.
- `Enable_chan`  out  2  channelizer enables: [0] narrow, [1] wide.
- `Enable_pdw`  out  2  PDW encoder enables: [0] narrow, [1] wide.
- `Last_sequence_num`  out  32  sequence number of the most recent valid-magic message.
- `Module_config`  out  struct  contains `valid`, `first`, `last`, `module_id[7:0]`, `message_type[7:0]`, `data[31:0]`.

## Operation
- A word transfers when `S_axis_valid && S_axis_ready`.
- `S_axis_ready` is 0 in reset and 1 at all other times; the block never backpressures.
- Message layout, by word index:
  - w0: magic.
  - w1: sequence number.
  - w2: {module_id[31:24], message_type[23:16], 16'h0000}.
  - w3: pad (ignored).
  - w4 onward: payload.
- State machine:
  - States: HDR_MAGIC, HDR_SEQ, HDR_TYPE, HDR_PAD, PAYLOAD, DROP.
  - Reset state is HDR_MAGIC.
  - Each state advances on each transferred word.
  - HDR_MAGIC goes to DROP if the word ≠ `CONTROL_MAGIC_NUM`.
  - HDR_PAD goes to PAYLOAD.
  - PAYLOAD stays in PAYLOAD.
  - `S_axis_last` on any word returns the machine to HDR_MAGIC, overriding all other transitions.
  - DROP discards words until `S_axis_last`.
- Short messages: a message that ends before w4 produces no outputs and changes no enable registers. `Last_sequence_num` still updates at w1 if the magic was correct.
- Common enables message (module_id = `MODULE_ID_COMMON`, type = `MSG_TYPE_ENABLES`):
  - Decode happens on payload word 0 (w4).
  - Fields: bit0 → `Enable_status`; bits[9:8] → `Enable_chan`; bits[17:16] → `Enable_pdw`; bit24 → `Rst_out`.
  - Later payload words are ignored.
  - Nothing is emitted on `Module_config`.
- Common module ID with any other message type: the payload is ignored.
- Any other module ID: every payload word is forwarded on `Module_config`.
  - `valid` = 1.
  - `first` = 1 on w4 only.
  - `last` = `S_axis_last`.
  - `module_id` / `message_type` are latched from w2; `data` is the word.
- The sequence number is recorded, not checked.

## Timing
- Reset values:
  - `Rst_out` = 1.
  - `Enable_status` = 0.
  - `Enable_chan` = 0.
  - `Enable_pdw` = 0.
  - `Last_sequence_num` = 0.
  - All `Module_config` fields = 0.
  - State = HDR_MAGIC.
- All outputs are registered. An accepted word affects outputs on the following clock edge (1-cycle latency).
- `Module_config.valid` is a 1-cycle pulse per forwarded word and is 0 on idle cycles. Back-to-back words give back-to-back pulses.
- Enable and reset registers hold their value until the next enables message.
- `Rst_out` stays asserted until a message clears bit24.
- Reset mid-message discards the partial message. The next word is treated as w0.

## Test plan
- Reset, then enables message {magic, 0, 0x00000000, 0xDEADBEEF, 0x01000000, 0xDEADBEEF} → `Rst_out`=1, all enables 0. Next message with w4 = 0x00030300 → `Rst_out`=0, `Enable_chan`=3, `Enable_pdw`=3, `Enable_status`=0. `Module_config.valid` never asserts during either message.
- Dwell-entry message with w2 = 0x01000000 and 10 payload words → exactly 10 `valid` pulses with correct `data`, `module_id`=1, `type`=0; `first` on pulse 1, `last` on pulse 10.
- Bad magic (0x12345678) followed by a correct second message → the first message produces no effect; the second is decoded correctly.
- A 3-word message, then a valid message → no output from the 3-word message; the following message decodes normally.
- Sequence numbers 5 then 6 → `Last_sequence_num` reads 6.
- Deassert `S_axis_resetn` during payload word 3 → all outputs return to their reset values. A new full message after reset forwards from its own w4.

Source files
------------

// File: rtl/esm_config_decoder.sv
// ESM receiver control-message decoder: validates the 4-word stream header,
// applies common enables locally and forwards other payloads on Module_config.
package esm_config_pkg;
    typedef struct packed {
        logic        valid;
        logic        first;
        logic        last;
        logic [7:0]  module_id;
        logic [7:0]  message_type;
        logic [31:0] data;
    } module_config_t;
endpackage

module esm_config_decoder
    import esm_config_pkg::*;
#(
    parameter int          AXI_DATA_WIDTH    = 32,  // only 32 is supported
    parameter logic [31:0] CONTROL_MAGIC_NUM = 32'h45534D43,
    parameter logic [7:0]  MODULE_ID_COMMON  = 8'h00,
    parameter logic [7:0]  MSG_TYPE_ENABLES  = 8'h00
) (
    input  logic                      S_axis_clk,
    input  logic                      S_axis_resetn,
    output logic                      S_axis_ready,
    input  logic                      S_axis_valid,
    input  logic [AXI_DATA_WIDTH-1:0] S_axis_data,
    input  logic                      S_axis_last,
    output logic                      Rst_out,
    output logic                      Enable_status,
    output logic [1:0]                Enable_chan,
    output logic [1:0]                Enable_pdw,
    output logic [31:0]               Last_sequence_num,
    output module_config_t            Module_config
);

    typedef enum logic [2:0] {
        HDR_MAGIC,
        HDR_SEQ,
        HDR_TYPE,
        HDR_PAD,
        PAYLOAD,
        DROP
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_ready;
    logic           r_rst_out;
    logic           r_en_status;
    logic [1:0]     r_en_chan;
    logic [1:0]     r_en_pdw;
    logic [31:0]    r_seq;
    logic [7:0]     r_mod_id;
    logic [7:0]     r_msg_type;
    logic           r_pl_first;
    module_config_t r_cfg;

    logic           w_xfer;
    logic           w_is_common;
    logic           w_is_enables;

    assign w_xfer       = S_axis_valid && r_ready;
    assign w_is_common  = (r_mod_id == MODULE_ID_COMMON);
    assign w_is_enables = w_is_common && (r_msg_type == MSG_TYPE_ENABLES);

    always_ff @(posedge S_axis_clk) begin
        if (!S_axis_resetn) r_state <= HDR_MAGIC;
        else                r_state <= w_state_nxt;
    end

    // A last word always re-arms header parsing, whatever state we were in.
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            if (S_axis_last) begin
                w_state_nxt = HDR_MAGIC;
            end else begin
                case (r_state)
                    HDR_MAGIC: w_state_nxt = (S_axis_data == CONTROL_MAGIC_NUM) ? HDR_SEQ : DROP;
                    HDR_SEQ:   w_state_nxt = HDR_TYPE;
                    HDR_TYPE:  w_state_nxt = HDR_PAD;
                    HDR_PAD:   w_state_nxt = PAYLOAD;
                    PAYLOAD:   w_state_nxt = PAYLOAD;
                    DROP:      w_state_nxt = DROP;
                    default:   w_state_nxt = HDR_MAGIC;
                endcase
            end
        end
    end

    always_ff @(posedge S_axis_clk) begin
        if (!S_axis_resetn) begin
            r_ready     <= 1'b0;
            r_rst_out   <= 1'b1;
            r_en_status <= 1'b0;
            r_en_chan   <= 2'b00;
            r_en_pdw    <= 2'b00;
            r_seq       <= '0;
            r_mod_id    <= '0;
            r_msg_type  <= '0;
            r_pl_first  <= 1'b0;
            r_cfg       <= '0;
        end else begin
            r_ready     <= 1'b1;
            r_cfg.valid <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    HDR_SEQ:  r_seq <= S_axis_data;
                    HDR_TYPE: begin
                        r_mod_id   <= S_axis_data[31:24];
                        r_msg_type <= S_axis_data[23:16];
                    end
                    HDR_PAD:  r_pl_first <= 1'b1;
                    PAYLOAD: begin
                        r_pl_first <= 1'b0;
                        if (w_is_common) begin
                            // Only the first payload word of an enables message carries fields.
                            if (w_is_enables && r_pl_first) begin
                                r_en_status <= S_axis_data[0];
                                r_en_chan   <= S_axis_data[9:8];
                                r_en_pdw    <= S_axis_data[17:16];
                                r_rst_out   <= S_axis_data[24];
                            end
                        end else begin
                            r_cfg.valid        <= 1'b1;
                            r_cfg.first        <= r_pl_first;
                            r_cfg.last         <= S_axis_last;
                            r_cfg.module_id    <= r_mod_id;
                            r_cfg.message_type <= r_msg_type;
                            r_cfg.data         <= S_axis_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign S_axis_ready      = r_ready;
    assign Rst_out           = r_rst_out;
    assign Enable_status     = r_en_status;
    assign Enable_chan       = r_en_chan;
    assign Enable_pdw        = r_en_pdw;
    assign Last_sequence_num = r_seq;
    assign Module_config     = r_cfg;

endmodule

// File: tb/tb_esm_config_decoder.sv
// Scoreboard bench for esm_config_decoder: message-level reference model feeds
// an expected-output queue that a negedge monitor drains.
module tb_esm_config_decoder;
    import esm_config_pkg::*;

    localparam logic [31:0] MAGIC = 32'h45534D43;

    logic           clk = 1'b0;
    logic           S_axis_resetn;
    logic           S_axis_ready;
    logic           S_axis_valid;
    logic [31:0]    S_axis_data;
    logic           S_axis_last;
    logic           Rst_out;
    logic           Enable_status;
    logic [1:0]     Enable_chan;
    logic [1:0]     Enable_pdw;
    logic [31:0]    Last_sequence_num;
    module_config_t Module_config;

    int vectors = 0;
    int errors  = 0;

    module_config_t exp_q[$];
    logic        exp_rst;
    logic        exp_status;
    logic [1:0]  exp_chan;
    logic [1:0]  exp_pdw;
    logic [31:0] exp_seq;

    always #5 clk = ~clk;

    esm_config_decoder dut (
        .S_axis_clk        (clk),
        .S_axis_resetn     (S_axis_resetn),
        .S_axis_ready      (S_axis_ready),
        .S_axis_valid      (S_axis_valid),
        .S_axis_data       (S_axis_data),
        .S_axis_last       (S_axis_last),
        .Rst_out           (Rst_out),
        .Enable_status     (Enable_status),
        .Enable_chan       (Enable_chan),
        .Enable_pdw        (Enable_pdw),
        .Last_sequence_num (Last_sequence_num),
        .Module_config     (Module_config)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (S_axis_resetn && Module_config.valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_cfg: got data %h with nothing expected", Module_config.data);
            end else begin
                chk("cfg_word", 64'(Module_config), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        exp_rst    = 1'b1;
        exp_status = 1'b0;
        exp_chan   = 2'b00;
        exp_pdw    = 2'b00;
        exp_seq    = 32'h0;
    endtask

    // Whole-message reference: decide the message's effect from its word list.
    task automatic model_msg(input logic [31:0] m[$]);
        int n = m.size();
        logic [7:0] id;
        logic [7:0] ty;
        module_config_t e;
        if (n < 1 || m[0] != MAGIC) return;
        if (n >= 2) exp_seq = m[1];
        if (n < 5) return;
        id = m[2][31:24];
        ty = m[2][23:16];
        if (id == 8'h00) begin
            if (ty == 8'h00) begin
                exp_status = m[4][0];
                exp_chan   = m[4][9:8];
                exp_pdw    = m[4][17:16];
                exp_rst    = m[4][24];
            end
        end else begin
            for (int i = 4; i < n; i++) begin
                e = '{valid: 1'b1, first: (i == 4), last: (i == n - 1),
                      module_id: id, message_type: ty, data: m[i]};
                exp_q.push_back(e);
            end
        end
    endtask

    // Entered and left at a negedge; a random idle cycle may follow the word.
    task automatic send_word(input logic [31:0] w, input logic l);
        int n = 0;
        while (!S_axis_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!S_axis_ready) begin
            vectors++;
            errors++;
            $display("FAIL ready_timeout: got ready %b expected 1", S_axis_ready);
        end
        S_axis_valid = 1'b1;
        S_axis_data  = w;
        S_axis_last  = l;
        @(negedge clk);
        S_axis_valid = 1'b0;
        S_axis_last  = 1'b0;
        S_axis_data  = $urandom;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
    endtask

    task automatic send_msg(input logic [31:0] m[$]);
        model_msg(m);
        for (int i = 0; i < m.size(); i++) send_word(m[i], i == m.size() - 1);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "_rst"},    64'(Rst_out),           64'(exp_rst));
        chk({tag, "_status"}, 64'(Enable_status),     64'(exp_status));
        chk({tag, "_chan"},   64'(Enable_chan),       64'(exp_chan));
        chk({tag, "_pdw"},    64'(Enable_pdw),        64'(exp_pdw));
        chk({tag, "_seq"},    64'(Last_sequence_num), 64'(exp_seq));
        chk({tag, "_drain"},  64'(exp_q.size()),      64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] m[$];
        logic [7:0]  id, ty;
        int          len;
        module_config_t e;

        S_axis_resetn = 1'b0;
        S_axis_valid  = 1'b0;
        S_axis_data   = '0;
        S_axis_last   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(S_axis_ready), 64'd0);
        chk("rst_cfg",   64'(Module_config), 64'd0);
        check_state("reset");
        S_axis_resetn = 1'b1;
        @(negedge clk);

        // Enables: Rst_out kept high, then cleared with channel/PDW enables set.
        m = '{MAGIC, 32'd5, 32'h00000000, 32'hDEADBEEF, 32'h01000000, 32'hDEADBEEF};
        send_msg(m);
        check_state("en1");
        chk("en1_rst_lit", 64'(Rst_out), 64'd1);
        m = '{MAGIC, 32'd6, 32'h00000000, 32'hDEADBEEF, 32'h00030300, 32'hDEADBEEF};
        send_msg(m);
        check_state("en2");
        chk("en2_chan_lit", 64'(Enable_chan), 64'd3);
        chk("en2_pdw_lit",  64'(Enable_pdw),  64'd3);
        chk("en2_rst_lit",  64'(Rst_out),     64'd0);
        chk("seq6_lit",     64'(Last_sequence_num), 64'd6);

        // Dwell entry: ten forwarded payload words.
        m = '{MAGIC, 32'd7, 32'h01000000, 32'h0};
        for (int i = 0; i < 10; i++) m.push_back(32'hA000_0000 + i);
        send_msg(m);
        check_state("dwell");

        // Bad magic, then a good enables message.
        m = '{32'h12345678, 32'd99, 32'h00000000, 32'h0, 32'h01010101};
        send_msg(m);
        check_state("badmagic");
        m = '{MAGIC, 32'd8, 32'h00000000, 32'h0, 32'h00010001};
        send_msg(m);
        check_state("after_bad");

        // Three-word message, then a forwarding message.
        m = '{MAGIC, 32'd9, 32'h03000000};
        send_msg(m);
        check_state("short");
        m = '{MAGIC, 32'd10, 32'h03040000, 32'h0, 32'h11111111, 32'h22222222};
        send_msg(m);
        check_state("after_short");

        // Reset arrives with payload word 3 on the bus.
        m = '{MAGIC, 32'd11, 32'h02050000, 32'h0, 32'hB0, 32'hB1, 32'hB2};
        for (int i = 4; i < 7; i++) begin
            e = '{valid: 1'b1, first: (i == 4), last: 1'b0,
                  module_id: 8'h02, message_type: 8'h05, data: m[i]};
            exp_q.push_back(e);
        end
        for (int i = 0; i < 7; i++) send_word(m[i], 1'b0);
        S_axis_resetn = 1'b0;
        S_axis_valid  = 1'b1;
        S_axis_data   = 32'hB3;
        @(negedge clk);
        S_axis_resetn = 1'b1;
        S_axis_valid  = 1'b0;
        chk("midrst_cfg", 64'(Module_config), 64'd0);
        chk("midrst_ready", 64'(S_axis_ready), 64'd0);
        model_reset();
        check_state("midrst");
        m = '{MAGIC, 32'd12, 32'h02050000, 32'h0, 32'hC0, 32'hC1, 32'hC2};
        send_msg(m);
        check_state("post_rst");

        // Random messages of every shape.
        for (int k = 0; k < 40; k++) begin
            m.delete();
            len = $urandom_range(1, 12);
            case ($urandom_range(0, 2))
                0:       id = 8'h00;
                1:       id = 8'h01;
                default: id = 8'($urandom_range(1, 255));
            endcase
            ty = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            for (int i = 0; i < len; i++) begin
                case (i)
                    0:       m.push_back(($urandom_range(0, 4) == 0) ? 32'($urandom) : MAGIC);
                    2:       m.push_back({id, ty, 16'h0000});
                    default: m.push_back(32'($urandom));
                endcase
            end
            send_msg(m);
            check_state("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
